// File: rtl/peridot_config_ru_multi.sv
// Remote-update sequencer: resets the config core, reports the running image, then reconfigures
// into a host-selected image on an nconfig rise. Watchdog fallback: PERIDOT_RU_WATCHDOG_EN.
module peridot_config_ru_multi #(
  parameter int unsigned IMAGE_NUM          = 2,
  parameter int unsigned INIT_WAIT_CYCLE    = 16,
  parameter int unsigned RECONF_DELAY_CYCLE = 10,
  parameter int unsigned POLL_LIMIT         = 255,
  parameter int unsigned WDT_CYCLE          = 50000000
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic        ru_nconfig,
  output logic        ru_ready,
  output logic [2:0]  ru_bootsel,
  output logic        ru_nstatus,
  output logic        ru_error,
  input  logic        req_valid,
  input  logic [2:0]  req_image,
  output logic        req_ready,
  output logic        dc_nreset,
  output logic [2:0]  dc_address,
  output logic        dc_write,
  output logic [31:0] dc_writedata,
  output logic        dc_read,
  input  logic [31:0] dc_readdata
`ifdef PERIDOT_RU_WATCHDOG_EN
  ,
  input  logic        wd_kick
`endif
);

  typedef enum logic [3:0] {
    StInit, StLatch, StPoll, StPollData, StStat, StStatData,
    StIdle, StDelay, StSel, StTrig, StHalt, StError
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sync_q;
  logic        rise;
  logic [7:0]  init_cnt_q, init_cnt_d;
  logic [9:0]  poll_cnt_q, poll_cnt_d;
  logic [26:0] delay_cnt_q, delay_cnt_d;
  logic [2:0]  target_q, target_d;
  logic [2:0]  bootsel_q, bootsel_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        wdt_expired;
  logic [28:0] unused_readdata;

  assign unused_readdata = dc_readdata[31:3];

  // Synchroniser idles high so reset never manufactures a rising edge.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) sync_q <= 3'b111;
    else           sync_q <= {sync_q[1:0], ru_nconfig};
  end

  assign rise = sync_q[1] & ~sync_q[2];

`ifdef PERIDOT_RU_WATCHDOG_EN
  logic [31:0] wdt_cnt_q, wdt_cnt_d;

  always_comb begin
    wdt_cnt_d = '0;
    if (state_q == StIdle) wdt_cnt_d = wd_kick ? '0 : wdt_cnt_q + 32'd1;
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) wdt_cnt_q <= '0;
    else           wdt_cnt_q <= wdt_cnt_d;
  end

  assign wdt_expired = (state_q == StIdle) && !wd_kick && (wdt_cnt_q == 32'(WDT_CYCLE - 1));
`else
  logic [31:0] unused_wdt;
  assign unused_wdt  = 32'(WDT_CYCLE);
  assign wdt_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    delay_cnt_d  = delay_cnt_q;
    target_d     = target_q;
    bootsel_d    = bootsel_q;
    dc_nreset    = 1'b1;
    dc_address   = '0;
    dc_write     = 1'b0;
    dc_writedata = '0;
    dc_read      = 1'b0;
    unique case (state_q)
      StInit: begin
        dc_nreset = 1'b0;
        if (init_cnt_q == 8'(INIT_WAIT_CYCLE)) state_d = StLatch;
        else init_cnt_d = init_cnt_q + 8'd1;
      end
      StLatch: begin
        dc_write     = 1'b1;
        dc_address   = 3'd2;
        dc_writedata = 32'd1;
        poll_cnt_d   = '0;
        state_d      = StPoll;
      end
      StPoll: begin
        dc_read    = 1'b1;
        dc_address = 3'd3;
        state_d    = StPollData;
      end
      StPollData: begin
        dc_read    = 1'b1;
        dc_address = 3'd3;
        if (dc_readdata[0]) begin
          poll_cnt_d = poll_cnt_q + 10'd1;
          state_d    = (poll_cnt_d == 10'(POLL_LIMIT)) ? StError : StPoll;
        end else begin
          state_d = StStat;
        end
      end
      StStat: begin
        dc_read    = 1'b1;
        dc_address = 3'd4;
        state_d    = StStatData;
      end
      StStatData: begin
        dc_read    = 1'b1;
        dc_address = 3'd4;
        bootsel_d  = dc_readdata[2:0];
        state_d    = StIdle;
      end
      StIdle: begin
        if (req_valid && (32'(req_image) < IMAGE_NUM)) target_d = req_image;
        // An nconfig rise wins over a simultaneous watchdog expiry.
        if (rise) begin
          delay_cnt_d = 27'(RECONF_DELAY_CYCLE);
          state_d     = StDelay;
        end else if (wdt_expired) begin
          target_d    = '0;
          delay_cnt_d = 27'(RECONF_DELAY_CYCLE);
          state_d     = StDelay;
        end
      end
      StDelay: begin
        if (delay_cnt_q == '0) state_d = StSel;
        else delay_cnt_d = delay_cnt_q - 27'd1;
      end
      StSel: begin
        dc_write     = 1'b1;
        dc_address   = 3'd1;
        dc_writedata = {29'b0, target_q};
        state_d      = StTrig;
      end
      StTrig: begin
        dc_write     = 1'b1;
        dc_address   = 3'd0;
        dc_writedata = 32'd1;
        state_d      = StHalt;
      end
      StHalt:  state_d = StHalt;
      StError: state_d = StError;
      default: state_d = StInit;
    endcase
    // Ready is asserted from the first full IDLE cycle and drops on the way out.
    ready_d = (state_q == StIdle) && (state_d == StIdle);
    error_d = error_q | (state_d == StError);
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      poll_cnt_q  <= '0;
      delay_cnt_q <= '0;
      target_q    <= '0;
      bootsel_q   <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      target_q    <= target_d;
      bootsel_q   <= bootsel_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign ru_ready   = ready_q;
  assign ru_error   = error_q;
  assign ru_bootsel = bootsel_q;
  assign ru_nstatus = ready_q & sync_q[2];
  assign req_ready  = (state_q == StIdle);

endmodule
